// File: rtl/alu_seq_register_if.sv
// Operand/function request and result handshake between the accumulator ALU and its user.
// master drives operands and start; slave (the ALU) returns ready, done and the accumulator.
interface alu_seq_register_if;
  logic [3:0] data_a;
  logic [2:0] func;
  logic       start;
  logic       ready;
  logic       done;
  logic [7:0] result;

  modport master (
    output data_a, func, start,
    input  ready, done, result
  );

  modport slave (
    input  data_a, func, start,
    output ready, done, result
  );
endinterface

// File: rtl/alu_seq_register.sv
// Multi-cycle accumulator ALU: B is result[3:0]; result updates only on EXEC->DONE (2 to 8 cycles after accept).
// Accepts one request per IDLE visit; start while busy is dropped, not queued.
module alu_seq_register (
  input logic               clock,
  input logic               reset,
  alu_seq_register_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [2:0] f_q;
  logic [2:0] cnt_q;
  logic [7:0] work_q;
  logic [7:0] mcand_q;
  logic [7:0] result_q;

  logic       accept;
  logic [4:0] ripple_sum;
  logic       carry;
  logic [7:0] single_res;
  logic [7:0] work_nxt;
  logic [7:0] op_res;

  assign accept     = bus.start && (state == S_IDLE);
  assign bus.ready  = (state == S_IDLE);
  assign bus.done   = (state == S_DONE);
  assign bus.result = result_q;

  always_comb begin
    carry      = 1'b0;
    ripple_sum = 5'd0;
    for (int i = 0; i < 4; i++) begin
      ripple_sum[i] = a_q[i] ^ b_q[i] ^ carry;
      carry         = (a_q[i] & b_q[i]) | (carry & (a_q[i] ^ b_q[i]));
    end
    ripple_sum[4] = carry;
  end

  always_comb begin
    single_res = 8'h00;
    case (f_q)
      3'b000:  single_res = {3'b000, {1'b0, a_q} + 5'd1};
      3'b001:  single_res = {3'b000, ripple_sum};
      3'b010:  single_res = {3'b000, {1'b0, a_q} + {1'b0, b_q}};
      3'b011:  single_res = {a_q | b_q, a_q ^ b_q};
      3'b100:  single_res = {7'b0000000, |{a_q, b_q}};
      3'b101:  single_res = {a_q, b_q};
      default: single_res = 8'h00;
    endcase
  end

  // Shift uses work_q as the shifting operand; multiply uses it as the partial product.
  always_comb begin
    work_nxt = work_q;
    if (f_q == 3'b110) begin
      if (a_q[2:0] != 3'd0)
        work_nxt = {work_q[6:0], 1'b0};
    end else begin
      work_nxt = work_q + (b_q[0] ? mcand_q : 8'h00);
    end
    op_res = (f_q[2:1] == 2'b11) ? work_nxt : single_res;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      a_q      <= 4'h0;
      b_q      <= 4'h0;
      f_q      <= 3'd0;
      cnt_q    <= 3'd0;
      work_q   <= 8'h00;
      mcand_q  <= 8'h00;
      result_q <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state   <= S_EXEC;
            a_q     <= bus.data_a;
            b_q     <= result_q[3:0];
            f_q     <= bus.func;
            mcand_q <= {4'h0, bus.data_a};
            work_q  <= (bus.func == 3'b110) ? {4'h0, result_q[3:0]} : 8'h00;
            if (bus.func == 3'b110)
              cnt_q <= (bus.data_a[2:0] == 3'd0) ? 3'd1 : bus.data_a[2:0];
            else if (bus.func == 3'b111)
              cnt_q <= 3'd4;
            else
              cnt_q <= 3'd1;
          end
        end
        S_EXEC: begin
          cnt_q   <= cnt_q - 3'd1;
          work_q  <= work_nxt;
          mcand_q <= {mcand_q[6:0], 1'b0};
          // B doubles as the multiplier shift register; no other op reads it after its single cycle.
          if (f_q == 3'b111)
            b_q <= {1'b0, b_q[3:1]};
          if (cnt_q == 3'd1) begin
            state    <= S_DONE;
            result_q <= op_res;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_register.sv
// Self-checking bench for alu_seq_register: directed scenarios plus randomized ops against an arithmetic model.
module tb_alu_seq_register;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_seq_register_if bus ();

  alu_seq_register dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] model_res(input int a, input int f, input int b);
    int r;
    case (f)
      0:       r = a + 1;
      1, 2:    r = a + b;
      3:       r = (a | b) * 16 + (a ^ b);
      4:       r = (a != 0 || b != 0) ? 1 : 0;
      5:       r = a * 16 + b;
      6:       r = (b * (1 << (a % 8))) % 256;
      default: r = a * b;
    endcase
    return r[7:0];
  endfunction

  function automatic int model_lat(input int a, input int f);
    if (f == 6) return 1 + (((a % 8) == 0) ? 1 : (a % 8));
    if (f == 7) return 5;
    return 2;
  endfunction

  task automatic reset_dut();
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.data_a = 4'h0;
    bus.func   = 3'd0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Drives one request and reports what was observed; cycle 1 is the first cycle after the accept edge.
  task automatic run_op(input logic [3:0] a, input logic [2:0] f, output int lat,
                        output logic [7:0] res, output bit stable, output bit pulse_ok,
                        output bit rdy_back);
    logic [7:0] pre;
    int c;
    lat = -1; res = 8'hxx; stable = 1'b1; pulse_ok = 1'b0; rdy_back = 1'b0;
    @(negedge clock);
    c = 0;
    while (bus.ready !== 1'b1 && c < 20) begin
      @(negedge clock);
      c++;
    end
    bus.data_a = a;
    bus.func   = f;
    bus.start  = 1'b1;
    pre        = bus.result;
    @(negedge clock);
    bus.start  = 1'b0;
    bus.data_a = 4'($urandom);
    bus.func   = 3'($urandom);
    for (int k = 1; k <= 12; k++) begin
      if (bus.done === 1'b1) begin
        lat = k;
        res = bus.result;
        break;
      end
      if (bus.result !== pre || bus.ready !== 1'b0) stable = 1'b0;
      @(negedge clock);
    end
    if (lat > 0) begin
      @(negedge clock);
      pulse_ok = (bus.done === 1'b0);
      rdy_back = (bus.ready === 1'b1);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    @(negedge clock);
    n_checks++;
    if (bus.result !== 8'h00) begin n_fail++; $display("FAIL reset_result: got %h want 00", bus.result); end
    n_checks++;
    if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
  endtask

  task automatic test_single_cycle();
    int lat; logic [7:0] res; bit st, po, rb;
    run_op(4'h3, 3'b101, lat, res, st, po, rb);
    n_checks++;
    if (res !== 8'h30) begin n_fail++; $display("FAIL concat_result: got %h want 30", res); end
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL concat_done_cycle: got %0d want 2", lat); end
    n_checks++;
    if (!(st && po && rb)) begin n_fail++; $display("FAIL concat_handshake: stable=%b pulse=%b ready3=%b want 111", st, po, rb); end
  endtask

  task automatic test_chain();
    logic [3:0] as [4] = '{4'h5, 4'h9, 4'h9, 4'h6};
    logic [2:0] fs [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [7:0] ex [4] = '{8'h06, 8'h0F, 8'h18, 8'hEE};
    int lat; logic [7:0] res; bit st, po, rb;
    for (int i = 0; i < 4; i++) begin
      run_op(as[i], fs[i], lat, res, st, po, rb);
      n_checks++;
      if (res !== ex[i] || lat !== 2) begin
        n_fail++;
        $display("FAIL chain_%0d: got %h at cycle %0d want %h at cycle 2", i, res, lat, ex[i]);
      end
    end
  endtask

  task automatic test_multiply();
    int lat; logic [7:0] res; bit st, po, rb;
    reset_dut();
    run_op(4'hF, 3'd2, lat, res, st, po, rb);
    run_op(4'hF, 3'd7, lat, res, st, po, rb);
    n_checks++;
    if (res !== 8'hE1) begin n_fail++; $display("FAIL mul_result: got %h want e1", res); end
    n_checks++;
    if (lat !== 5) begin n_fail++; $display("FAIL mul_done_cycle: got %0d want 5", lat); end
    n_checks++;
    if (!st) begin n_fail++; $display("FAIL mul_hold: result/ready changed in cycles 1-4 (stable=%b want 1)", st); end
  endtask

  task automatic test_shift();
    int lat; logic [7:0] res; bit st, po, rb;
    reset_dut();
    run_op(4'hF, 3'd2, lat, res, st, po, rb);
    run_op(4'h4, 3'd6, lat, res, st, po, rb);
    n_checks++;
    if (res !== 8'hF0 || lat !== 5) begin n_fail++; $display("FAIL shl4: got %h at %0d want f0 at 5", res, lat); end
    run_op(4'h0, 3'd6, lat, res, st, po, rb);
    n_checks++;
    if (res !== 8'h00 || lat !== 2) begin n_fail++; $display("FAIL shl0: got %h at %0d want 00 at 2", res, lat); end
    run_op(4'hF, 3'd2, lat, res, st, po, rb);
    run_op(4'h7, 3'd6, lat, res, st, po, rb);
    n_checks++;
    if (res !== 8'h80 || lat !== 8) begin n_fail++; $display("FAIL shl7: got %h at %0d want 80 at 8", res, lat); end
  endtask

  task automatic test_hold_start();
    logic [7:0] acc, pending;
    bit has_pending;
    int accepts, dones;
    reset_dut();
    acc = 8'h00; has_pending = 1'b0; accepts = 0; dones = 0;
    @(negedge clock);
    bus.func  = 3'd1;
    bus.start = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (bus.done === 1'b1) begin
        dones++;
        n_checks++;
        if (!has_pending || bus.result !== pending) begin
          n_fail++;
          $display("FAIL hold_result_%0d: got %h want %h", dones, bus.result, pending);
        end
        acc = pending;
        has_pending = 1'b0;
      end
      bus.data_a = 4'($urandom);
      if (bus.ready === 1'b1) begin
        accepts++;
        pending = model_res(int'(bus.data_a), 1, int'(acc[3:0]));
        has_pending = 1'b1;
      end
      @(negedge clock);
    end
    bus.start = 1'b0;
    n_checks++;
    if (accepts !== 10 || dones !== 10) begin
      n_fail++;
      $display("FAIL hold_counts: accepts=%0d dones=%0d want 10 and 10", accepts, dones);
    end
  endtask

  task automatic test_random();
    logic [7:0] acc;
    logic [3:0] a;
    logic [2:0] f;
    logic [7:0] exp;
    int lat; logic [7:0] res; bit st, po, rb;
    reset_dut();
    acc = 8'h00;
    for (int i = 0; i < 40; i++) begin
      a = 4'($urandom);
      f = 3'($urandom);
      exp = model_res(int'(a), int'(f), int'(acc[3:0]));
      run_op(a, f, lat, res, st, po, rb);
      n_checks++;
      if (res !== exp) begin n_fail++; $display("FAIL rand_result_%0d: a=%h f=%0d got %h want %h", i, a, f, res, exp); end
      n_checks++;
      if (lat !== model_lat(int'(a), int'(f))) begin
        n_fail++;
        $display("FAIL rand_latency_%0d: a=%h f=%0d got %0d want %0d", i, a, f, lat, model_lat(int'(a), int'(f)));
      end
      n_checks++;
      if (!(st && po && rb)) begin n_fail++; $display("FAIL rand_handshake_%0d: stable=%b pulse=%b ready=%b want 111", i, st, po, rb); end
      acc = exp;
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [7:0] res; bit st, po, rb;
    bit saw_done;
    run_op(4'hF, 3'd2, lat, res, st, po, rb);
    @(negedge clock);
    bus.data_a = 4'hF; bus.func = 3'd7; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.result !== 8'h00 || bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_state: result=%h ready=%b done=%b want 00 1 0", bus.result, bus.ready, bus.done);
    end
    @(negedge clock);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clock);
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin n_fail++; $display("FAIL midreset_no_done: got done pulse want none"); end
    run_op(4'h3, 3'b101, lat, res, st, po, rb);
    n_checks++;
    if (res !== 8'h30 || lat !== 2) begin n_fail++; $display("FAIL midreset_next_op: got %h at %0d want 30 at 2", res, lat); end
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.data_a = 4'h0;
    bus.func   = 3'd0;
    test_reset();
    test_single_cycle();
    test_chain();
    test_multiply();
    test_shift();
    test_hold_start();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
